// File: rtl/loop_cache.sv
// Direct-mapped loop buffer sitting between the fetch unit and instruction memory.
// A short backward taken branch arms the buffer. The loop body is captured as it streams
// from memory, and later iterations are served locally without a memory access.
module loop_cache #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DEPTH_W = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_rd_i,
    input  logic [31:0] fetch_pc_i,
    output logic        fetch_accept_o,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_inst_o,
    output logic        mem_rd_o,
    output logic [31:0] mem_pc_o,
    input  logic        mem_accept_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_inst_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_src_pc_i,
    input  logic [31:0] branch_tgt_pc_i,
    input  logic        flush_i,
    output logic [31:0] hit_count_o,
    output logic [31:0] access_count_o
);

    typedef enum logic [1:0] {StIdle, StFill, StActive} state_e;

    state_e               state_q, state_d;
    logic [31:0]          start_q, end_q;
    logic [DEPTH-1:0]     valid_q;
    logic [31:0]          data_q [DEPTH];
    logic                 pend_q, pend_hit_q;
    logic [31:0]          pend_pc_q;
    logic [DEPTH_W-1:0]   pend_hit_idx_q;
    logic [31:0]          hit_cnt_q, acc_cnt_q;

    logic [31:0]          pc_a, pc_off, pend_off, src_a, tgt_a, span;
    logic [DEPTH_W-1:0]   idx, pend_idx;
    logic                 in_range, pend_in_range, hit, resp_now, accept;
    logic                 br_qual, br_same, clear_valid, load_bounds, capture;
    logic                 unused_bits;

    // Address decode for the incoming request and for the outstanding one
    always_comb begin
        pc_a          = {fetch_pc_i[31:2], 2'b00};
        pc_off        = pc_a - start_q;
        idx           = pc_off[DEPTH_W+1:2];
        in_range      = (pc_a >= start_q) && (pc_a <= end_q);
        hit           = in_range && valid_q[idx] && (state_q != StIdle);
        pend_off      = pend_pc_q - start_q;
        pend_idx      = pend_off[DEPTH_W+1:2];
        pend_in_range = (pend_pc_q >= start_q) && (pend_pc_q <= end_q);
        // The single outstanding request returns this cycle
        resp_now      = pend_q && (pend_hit_q || mem_valid_i);
        src_a         = {branch_src_pc_i[31:2], 2'b00};
        tgt_a         = {branch_tgt_pc_i[31:2], 2'b00};
        span          = src_a - tgt_a;
        // Loop of at most DEPTH words: span < DEPTH*4
        br_qual       = branch_taken_i && (tgt_a <= src_a) && (span[31:DEPTH_W+2] == '0);
        br_same       = (tgt_a == start_q) && (src_a == end_q) && (state_q != StIdle);
    end

    // Request acceptance, memory pass-through and response mux; all held at 0 in reset
    always_comb begin
        mem_rd_o       = 1'b0;
        mem_pc_o       = 32'h0;
        accept         = 1'b0;
        fetch_valid_o  = 1'b0;
        fetch_inst_o   = 32'h0;
        if (!rst_i) begin
            mem_pc_o = fetch_pc_i;
            if (hit) begin
                // Hits may follow a returning response back to back
                accept = fetch_rd_i && (!pend_q || resp_now);
            end else begin
                mem_rd_o = fetch_rd_i && !pend_q;
                accept   = mem_rd_o && mem_accept_i;
            end
            if (pend_q && pend_hit_q) begin
                fetch_valid_o = 1'b1;
                fetch_inst_o  = data_q[pend_hit_idx_q];
            end else begin
                fetch_valid_o = pend_q && mem_valid_i;
                fetch_inst_o  = mem_inst_i;
            end
        end
    end

    assign fetch_accept_o = accept;

    // Next state: flush > qualifying branch > exit > fill completion
    always_comb begin
        state_d     = state_q;
        clear_valid = 1'b0;
        load_bounds = 1'b0;
        if (flush_i) begin
            state_d     = StIdle;
            clear_valid = 1'b1;
        end else if (br_qual && !br_same) begin
            state_d     = StFill;
            clear_valid = 1'b1;
            load_bounds = 1'b1;
        end else if ((state_q != StIdle) && accept && !in_range) begin
            state_d = StIdle;
        end else if ((state_q == StFill) && capture && (pend_pc_q == end_q)) begin
            state_d = StActive;
        end
    end

    // Any in-range memory response while armed is captured, wrong-path ones included
    always_comb begin
        capture = pend_q && !pend_hit_q && mem_valid_i && (state_q != StIdle) &&
                  pend_in_range && !clear_valid;
    end

    // State, loop bounds and valid bits
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            start_q <= 32'h0;
            end_q   <= 32'h0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_bounds) begin
                start_q <= tgt_a;
                end_q   <= src_a;
            end
            if (clear_valid) begin
                valid_q <= '0;
            end else if (capture) begin
                valid_q[pend_idx] <= 1'b1;
            end
        end
    end

    // Captured instruction storage, qualified by valid_q so no reset is needed
    always_ff @(posedge clk_i) begin
        if (capture) begin
            data_q[pend_idx] <= mem_inst_i;
        end
    end

    // Outstanding request tracking; reset drops any in-flight response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q         <= 1'b0;
            pend_hit_q     <= 1'b0;
            pend_pc_q      <= 32'h0;
            pend_hit_idx_q <= '0;
        end else if (accept) begin
            pend_q         <= 1'b1;
            pend_hit_q     <= hit;
            pend_pc_q      <= pc_a;
            pend_hit_idx_q <= idx;
        end else if (resp_now) begin
            pend_q <= 1'b0;
        end
    end

    // Efficiency counters, wrapping modulo 2^32
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q <= 32'h0;
            acc_cnt_q <= 32'h0;
        end else if (accept) begin
            acc_cnt_q <= acc_cnt_q + 32'd1;
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count_o    = hit_cnt_q;
    assign access_count_o = acc_cnt_q;

    assign unused_bits = ^{fetch_pc_i[1:0], branch_src_pc_i[1:0], branch_tgt_pc_i[1:0],
                           pc_off[31:DEPTH_W+2], pc_off[1:0], pend_off[31:DEPTH_W+2],
                           pend_off[1:0], span[DEPTH_W+1:0]};

endmodule

// File: tb/tb_loop_cache.sv
// Directed bench for loop_cache: reset, loop capture/hits, exit, oversize, flush, stall.
module tb_loop_cache;

    logic        clk;
    logic        rst;
    logic        fetch_rd;
    logic [31:0] fetch_pc;
    logic        fetch_accept_o;
    logic        fetch_valid_o;
    logic [31:0] fetch_inst_o;
    logic        mem_rd_o;
    logic [31:0] mem_pc_o;
    logic        mem_accept;
    logic        mem_valid;
    logic [31:0] mem_inst;
    logic        branch_taken;
    logic [31:0] branch_src;
    logic [31:0] branch_tgt;
    logic        flush;
    logic [31:0] hit_count_o;
    logic [31:0] access_count_o;

    int checks = 0;
    int errors = 0;
    int mem_reads = 0;

    loop_cache #(.DEPTH(16), .DEPTH_W(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .fetch_rd_i     (fetch_rd),
        .fetch_pc_i     (fetch_pc),
        .fetch_accept_o (fetch_accept_o),
        .fetch_valid_o  (fetch_valid_o),
        .fetch_inst_o   (fetch_inst_o),
        .mem_rd_o       (mem_rd_o),
        .mem_pc_o       (mem_pc_o),
        .mem_accept_i   (mem_accept),
        .mem_valid_i    (mem_valid),
        .mem_inst_i     (mem_inst),
        .branch_taken_i (branch_taken),
        .branch_src_pc_i(branch_src),
        .branch_tgt_pc_i(branch_tgt),
        .flush_i        (flush),
        .hit_count_o    (hit_count_o),
        .access_count_o (access_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count memory requests the memory side actually took
    always @(posedge clk) begin
        if (mem_rd_o && mem_accept) mem_reads <= mem_reads + 1;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0000;
    endfunction

    // One fetch: request, then response (from buffer next cycle, or from memory one cycle later)
    task automatic do_fetch(input logic [31:0] pc, input logic exp_hit);
        @(negedge clk);
        fetch_rd = 1'b1; fetch_pc = pc; mem_accept = 1'b1;
        #1;
        checks++;
        if (mem_rd_o !== ~exp_hit) begin
            errors++;
            $display("FAIL fetch_mem_rd pc=%h got %b want %b", pc, mem_rd_o, ~exp_hit);
        end
        checks++;
        if (fetch_accept_o !== 1'b1) begin
            errors++;
            $display("FAIL fetch_accept pc=%h got %b want 1", pc, fetch_accept_o);
        end
        checks++;
        if (fetch_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL fetch_early_valid pc=%h got %b want 0", pc, fetch_valid_o);
        end
        @(posedge clk);
        @(negedge clk);
        fetch_rd = 1'b0;
        if (!exp_hit) begin
            #1;
            checks++;
            if (fetch_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL miss_wait_valid pc=%h got %b want 0", pc, fetch_valid_o);
            end
            mem_valid = 1'b1;
            mem_inst  = mem_word(pc);
        end
        #1;
        checks++;
        if (fetch_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL resp_valid pc=%h got %b want 1", pc, fetch_valid_o);
        end
        checks++;
        if (fetch_inst_o !== mem_word(pc)) begin
            errors++;
            $display("FAIL resp_inst pc=%h got %h want %h", pc, fetch_inst_o, mem_word(pc));
        end
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        mem_inst  = 32'h0;
    endtask

    task automatic do_branch(input logic [31:0] src, input logic [31:0] tgt, input logic fl);
        @(negedge clk);
        branch_taken = 1'b1; branch_src = src; branch_tgt = tgt; flush = fl;
        @(negedge clk);
        branch_taken = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_rd = 1'b1; fetch_pc = 32'h10; mem_accept = 1'b1;
        mem_valid = 1'b1; mem_inst = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({fetch_valid_o, fetch_accept_o, mem_rd_o} !== 3'b000) begin
                errors++;
                $display("FAIL reset_ctrl cyc=%0d got %b want 000", c,
                         {fetch_valid_o, fetch_accept_o, mem_rd_o});
            end
            checks++;
            if (mem_pc_o !== 32'h0 || fetch_inst_o !== 32'h0) begin
                errors++;
                $display("FAIL reset_data cyc=%0d got %h/%h want 0/0", c, mem_pc_o,
                         fetch_inst_o);
            end
            checks++;
            if (hit_count_o !== 32'h0 || access_count_o !== 32'h0) begin
                errors++;
                $display("FAIL reset_counters cyc=%0d got %0d/%0d want 0/0", c, hit_count_o,
                         access_count_o);
            end
        end
        @(negedge clk);
        rst = 1'b0; fetch_rd = 1'b0; mem_valid = 1'b0; mem_inst = 32'h0;
        #1;
        checks++;
        if (fetch_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_stale_resp got %b want 0", fetch_valid_o);
        end
    endtask

    task automatic test_loop();
        int reads_before;
        for (int a = 0; a < 8; a++) do_fetch(32'(a * 4), 1'b0);
        do_branch(32'h1C, 32'h10, 1'b0);
        // Fill pass, then two passes served from the buffer
        for (int a = 0; a < 4; a++) do_fetch(32'h10 + 32'(a * 4), 1'b0);
        do_branch(32'h1C, 32'h10, 1'b0);
        reads_before = mem_reads;
        for (int it = 0; it < 2; it++) begin
            for (int a = 0; a < 4; a++) do_fetch(32'h10 + 32'(a * 4), 1'b1);
            do_branch(32'h1C, 32'h10, 1'b0);
        end
        checks++;
        if (mem_reads != reads_before) begin
            errors++;
            $display("FAIL loop_mem_reads got %0d want 0", mem_reads - reads_before);
        end
        checks++;
        if (hit_count_o !== 32'd8 || access_count_o !== 32'd20) begin
            errors++;
            $display("FAIL loop_counters got %0d/%0d want 8/20", hit_count_o, access_count_o);
        end
    endtask

    task automatic test_exit();
        do_fetch(32'h20, 1'b0);
        do_fetch(32'h10, 1'b0);
        checks++;
        if (hit_count_o !== 32'd8 || access_count_o !== 32'd22) begin
            errors++;
            $display("FAIL exit_counters got %0d/%0d want 8/22", hit_count_o, access_count_o);
        end
    endtask

    task automatic test_oversize();
        do_branch(32'h40, 32'h00, 1'b0);
        do_fetch(32'h00, 1'b0);
        do_fetch(32'h00, 1'b0);
        checks++;
        if (hit_count_o !== 32'd8) begin
            errors++;
            $display("FAIL oversize_hits got %0d want 8", hit_count_o);
        end
    endtask

    task automatic test_flush_branch();
        do_branch(32'h1C, 32'h10, 1'b0);
        for (int a = 0; a < 4; a++) do_fetch(32'h10 + 32'(a * 4), 1'b0);
        do_fetch(32'h10, 1'b1);
        do_branch(32'h1C, 32'h10, 1'b1);
        do_fetch(32'h10, 1'b0);
        do_fetch(32'h10, 1'b0);
        checks++;
        if (hit_count_o !== 32'd9 || access_count_o !== 32'd31) begin
            errors++;
            $display("FAIL flush_counters got %0d/%0d want 9/31", hit_count_o, access_count_o);
        end
    endtask

    task automatic test_stall();
        int reads_before;
        reads_before = mem_reads;
        @(negedge clk);
        fetch_rd = 1'b1; fetch_pc = 32'h30; mem_accept = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (mem_rd_o !== 1'b1 || mem_pc_o !== 32'h30) begin
                errors++;
                $display("FAIL stall_req cyc=%0d got %b/%h want 1/00000030", c, mem_rd_o,
                         mem_pc_o);
            end
            checks++;
            if (fetch_accept_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_accept cyc=%0d got %b want 0", c, fetch_accept_o);
            end
            @(negedge clk);
        end
        mem_accept = 1'b1;
        #1;
        checks++;
        if (fetch_accept_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_accept got %b want 1", fetch_accept_o);
        end
        @(negedge clk);
        fetch_rd = 1'b0;
        #1;
        checks++;
        if (fetch_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_early_valid got %b want 0", fetch_valid_o);
        end
        mem_valid = 1'b1; mem_inst = mem_word(32'h30);
        #1;
        checks++;
        if (fetch_valid_o !== 1'b1 || fetch_inst_o !== mem_word(32'h30)) begin
            errors++;
            $display("FAIL stall_resp got %b/%h want 1/%h", fetch_valid_o, fetch_inst_o,
                     mem_word(32'h30));
        end
        @(posedge clk);
        #1;
        mem_valid = 1'b0; mem_inst = 32'h0;
        @(negedge clk);
        #1;
        checks++;
        if (fetch_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_single_resp got %b want 0", fetch_valid_o);
        end
        checks++;
        if (mem_reads != reads_before + 1) begin
            errors++;
            $display("FAIL stall_mem_reads got %0d want 1", mem_reads - reads_before);
        end
        checks++;
        if (hit_count_o !== 32'd9 || access_count_o !== 32'd32) begin
            errors++;
            $display("FAIL stall_counters got %0d/%0d want 9/32", hit_count_o, access_count_o);
        end
    endtask

    initial begin
        fetch_rd = 1'b0; fetch_pc = 32'h0; mem_accept = 1'b1; mem_valid = 1'b0;
        mem_inst = 32'h0; branch_taken = 1'b0; branch_src = 32'h0; branch_tgt = 32'h0;
        flush = 1'b0; rst = 1'b1;
        test_reset();
        test_loop();
        test_exit();
        test_oversize();
        test_flush_branch();
        test_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
